// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared register width, stall FSM encoding and default latencies
package hazard_stall_unit_pkg;
  localparam int REG_AW = 3;
  localparam int LOAD_LAT_DEF = 1;
  localparam int ALU_LAT_DEF = 0;
  localparam int CNT_W_DEF = 2;
  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} stall_st_e;
endpackage

// File: rtl/hazard_stall_unit_sb_entry.sv
// sb_entry: saturating down-counter with synchronous load, one per architectural register
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: scoreboard-based load-use stall generator; HAZARD_PERF_CNT_EN adds perf counters
import hazard_stall_unit_pkg::*;
module hazard_stall_unit #(
  parameter int REG_AW   = hazard_stall_unit_pkg::REG_AW,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int ALU_LAT  = ALU_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic              issue,
  output logic              stall_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       bubble_events
`endif
);
  localparam int NREG = 2 ** REG_AW;
  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] load_val;
  logic haz;
  stall_st_e state_q, state_d;
  assign load_val = id_mem_read ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
  for (genvar g = 0; g < NREG; g++) begin : g_sb
    sb_entry #(.CNT_W(CNT_W)) u_sb (
      .clk(clk),
      .reset(reset),
      .load(issue & id_reg_write & (id_rd == REG_AW'(g))),
      .load_val(load_val),
      .cnt(cnt[g])
    );
  end
  assign haz = id_valid & ((id_use_rs1 & (cnt[id_rs1] != '0)) | (id_use_rs2 & (cnt[id_rs2] != '0)));
  // Outputs are forced low while reset is held so the pipeline sees no bubble or issue.
  always_comb begin
    stall   = reset & haz & ~flush;
    bubble  = reset & (stall | flush);
    issue   = reset & id_valid & ~stall & ~flush;
    state_d = stall ? ST_STALL : ST_RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= ST_RUN;
    else state_q <= state_d;
  assign stall_state = state_q;
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cycles  <= '0;
      bubble_events <= '0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 1'b1;
      if (stall && state_q == ST_RUN && bubble_events != '1) bubble_events <= bubble_events + 1'b1;
    end
`endif
endmodule
